// File: rtl/stream_detect_ctrl.sv
// stream_detect_ctrl
// Drives a 3-bit sequence detector with a latched WIDTH-bit pattern, one bit per clock.
// It clears the detector before each run and counts det_out pulses into a saturating counter.
// A busy/done handshake reports the count back to the top-level control.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; count and overflow hold the last run
// CLEAR  | detector held in clear for one cycle, first bit loaded
// SHIFT  | one pattern bit per cycle on det_in, det_out pulses counted
// DONE   | one-cycle done pulse, start ignored, then back to IDLE
`timescale 1ns/1ps
module stream_detect_ctrl #(
    parameter int WIDTH     = 16,
    parameter int CNT_W     = 5,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic             det_out,
    output logic             det_in,
    output logic             det_clr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow
);

    // One extra index bit so WIDTH-1 is always representable without wrapping.
    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [IDX_W-1:0] idx_q;
    logic             det_in_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic             last_bit;
    logic             next_bit;
    logic [WIDTH-1:0] shreg_next;

    assign last_bit   = (idx_q == LAST_IDX);
    assign next_bit   = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_next = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

    assign det_in      = det_in_q;
    assign match_count = cnt_q;
    assign overflow    = ovf_q;

    // State register; clr aborts any run without a done pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; det_clr also follows clr directly.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        det_clr = clr;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy    = 1'b1;
                det_clr = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pattern shifter, bit index, registered serial bit and saturating match counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            shreg_q  <= '0;
            idx_q    <= '0;
            det_in_q <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    det_in_q <= 1'b0;
                    if (start) begin
                        shreg_q <= pattern;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    det_in_q <= next_bit;
                    shreg_q  <= shreg_next;
                    idx_q    <= '0;
                end
                S_SHIFT: begin
                    if (det_out) begin
                        if (cnt_q == {CNT_W{1'b1}}) begin
                            ovf_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    if (last_bit) begin
                        det_in_q <= 1'b0;
                        idx_q    <= '0;
                    end else begin
                        det_in_q <= next_bit;
                        shreg_q  <= shreg_next;
                        idx_q    <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    det_in_q <= 1'b0;
                end
                default: begin
                    det_in_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_detect_ctrl.sv
// Bench for stream_detect_ctrl: three parameterisations, each wired to a behavioural
// 3-bit detector that fires on every fifth 1 since its last clear.
`timescale 1ns/1ps
module tb_stream_detect_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  start_v;
    logic [2:0]  clr_v;
    logic [2:0]  det_in_v;
    logic [2:0]  det_out_v;
    logic [2:0]  det_clr_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  ovf_v;
    logic [19:0] pat_v [3];
    logic [4:0]  cnt_a;
    logic [4:0]  cnt_b;
    logic [1:0]  cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    stream_detect_ctrl #(.WIDTH(16), .CNT_W(5), .MSB_FIRST(1)) u_a (
        .clk(clk), .clr(clr_v[0]), .start(start_v[0]), .pattern(pat_v[0][15:0]),
        .det_out(det_out_v[0]), .det_in(det_in_v[0]), .det_clr(det_clr_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .match_count(cnt_a), .overflow(ovf_v[0])
    );

    stream_detect_ctrl #(.WIDTH(16), .CNT_W(5), .MSB_FIRST(0)) u_b (
        .clk(clk), .clr(clr_v[1]), .start(start_v[1]), .pattern(pat_v[1][15:0]),
        .det_out(det_out_v[1]), .det_in(det_in_v[1]), .det_clr(det_clr_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .match_count(cnt_b), .overflow(ovf_v[1])
    );

    stream_detect_ctrl #(.WIDTH(20), .CNT_W(2), .MSB_FIRST(1)) u_c (
        .clk(clk), .clr(clr_v[2]), .start(start_v[2]), .pattern(pat_v[2]),
        .det_out(det_out_v[2]), .det_in(det_in_v[2]), .det_clr(det_clr_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .match_count(cnt_c), .overflow(ovf_v[2])
    );

    // Detector model: counts ones modulo 5 and fires combinationally on the fifth.
    for (genvar g = 0; g < 3; g++) begin : g_det
        logic [2:0] ones;
        always_ff @(posedge clk) begin
            if (det_clr_v[g]) begin
                ones <= 3'd0;
            end else if (det_in_v[g]) begin
                ones <= (ones == 3'd4) ? 3'd0 : ones + 3'd1;
            end
        end
        assign det_out_v[g] = det_in_v[g] & (ones == 3'd4);
    end

    function automatic int count_of(input int d);
        case (d)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full run on DUT d. lat stays -1 if done never appears within the budget.
    task automatic run(input int d, input logic [19:0] pat, input int restart_at,
                       output int lat, output int cnt, output int ov, output logic [19:0] pulses);
        @(posedge clk);
        @(negedge clk);
        pat_v[d]   = pat;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        pat_v[d]   = ~pat;
        check("busy_in_clear", int'(busy_v[d]), 1);
        check("det_clr_in_clear", int'(det_clr_v[d]), 1);
        lat    = -1;
        pulses = '0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (det_out_v[d] && k <= 20) pulses[k-1] = 1'b1;
            if (done_v[d]) lat = k;
            if (k == restart_at) begin
                start_v[d] = 1'b1;
                pat_v[d]   = 20'h0;
            end else begin
                start_v[d] = 1'b0;
            end
        end
        start_v[d] = 1'b0;
        cnt = count_of(d);
        ov  = int'(ovf_v[d]);
    endtask

    typedef struct {
        logic [15:0] pat;
        int          exp_cnt;
        logic [19:0] exp_pulses;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int lat;
        int cnt;
        int ov;
        int seen;
        logic [19:0] pulses;

        tbl[0] = '{16'hFFFF, 3, 20'h04210};
        tbl[1] = '{16'h0000, 0, 20'h00000};
        tbl[2] = '{16'hF800, 1, 20'h00010};
        tbl[3] = '{16'h001F, 1, 20'h08000};
        tbl[4] = '{16'h5555, 1, 20'h00200};
        tbl[5] = '{16'h03FF, 2, 20'h08400};
        tbl[6] = '{16'hFFFE, 3, 20'h04210};
        tbl[7] = '{16'h8421, 0, 20'h00000};

        start_v = '0;
        clr_v   = 3'b111;
        for (int i = 0; i < 3; i++) pat_v[i] = 20'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy_v[0]), 0);
        check("rst_done", int'(done_v[0]), 0);
        check("rst_count", int'(cnt_a), 0);
        check("rst_overflow", int'(ovf_v[0]), 0);
        check("rst_det_in", int'(det_in_v[0]), 0);
        check("rst_det_clr", int'(det_clr_v[0]), 1);
        @(negedge clk);
        clr_v = 3'b000;
        @(posedge clk);
        #1;
        check("idle_det_clr", int'(det_clr_v[0]), 0);

        for (int i = 0; i < 8; i++) begin
            run(0, {4'h0, tbl[i].pat}, 0, lat, cnt, ov, pulses);
            check($sformatf("tbl%0d_latency", i), lat, 17);
            check($sformatf("tbl%0d_count", i), cnt, tbl[i].exp_cnt);
            check($sformatf("tbl%0d_overflow", i), ov, 0);
            check($sformatf("tbl%0d_pulses", i), int'(pulses), int'(tbl[i].exp_pulses));
        end

        // start asserted mid-SHIFT must not disturb the run
        run(0, 20'h0FFFF, 5, lat, cnt, ov, pulses);
        check("restart_latency", lat, 17);
        check("restart_count", cnt, 3);

        // clr at bit 8 of an all-ones run
        @(posedge clk);
        @(negedge clk);
        pat_v[0]   = 20'h0FFFF;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_pre_det_in", int'(det_in_v[0]), 1);
        check("abort_pre_count", int'(cnt_a), 1);
        @(negedge clk);
        clr_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", int'(busy_v[0]), 0);
        check("abort_count", int'(cnt_a), 0);
        check("abort_det_clr", int'(det_clr_v[0]), 1);
        @(posedge clk);
        #1;
        check("abort_det_clr_held", int'(det_clr_v[0]), 1);
        @(negedge clk);
        clr_v[0] = 1'b0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) seen++;
        end
        check("abort_no_done", seen, 0);
        run(0, 20'h0FFFF, 0, lat, cnt, ov, pulses);
        check("after_abort_latency", lat, 17);
        check("after_abort_count", cnt, 3);

        // LSB-first ordering
        run(1, 20'h0001F, 0, lat, cnt, ov, pulses);
        check("lsb_001f_latency", lat, 17);
        check("lsb_001f_count", cnt, 1);
        check("lsb_001f_pulses", int'(pulses), 'h00010);
        run(1, 20'h0F800, 0, lat, cnt, ov, pulses);
        check("lsb_f800_count", cnt, 1);
        check("lsb_f800_pulses", int'(pulses), 'h08000);

        // narrow counter saturates, then a fresh run clears it
        run(2, 20'hFFFFF, 0, lat, cnt, ov, pulses);
        check("sat_latency", lat, 21);
        check("sat_count", cnt, 3);
        check("sat_overflow", ov, 1);
        check("sat_pulses", int'(pulses), 'h84210);
        run(2, 20'h00000, 0, lat, cnt, ov, pulses);
        check("sat_clear_count", cnt, 0);
        check("sat_clear_overflow", ov, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
